i2c_scl_gen: RTL and testbench

I2C_SCL_GEN -- requirements
Module: i2c_scl_gen

---
 rtl/i2c_scl_gen.sv | 198 +++++++++++++++++++
 tb/tb_i2c_scl_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_gen.sv
// ----------------------------------------------------------------------------
// i2c_scl_gen
//
// Purpose:
//   I2C master SCL clock generator with clock-stretching support and a
//   stretch timeout. The generator drives SCL low for H CLK cycles, then
//   releases it and waits for the bus to actually read high (slaves may hold
//   it low). Once high is seen, SCL stays released for another H cycles.
//   H = max(half_period, 4) is latched at the start of every low phase.
//   Unstretched SCL period is 2H+3 CLK cycles. The extra 3 cycles are the
//   release edge plus the two synchronizer flops.
//
// Ports:
//   CLK           in   system clock, rising edge
//   RST           in   synchronous active-high reset
//   en            in   run request; stopping happens only at the end of HIGH
//   half_period   in   CLK cycles per SCL low phase and per SCL high phase
//   stretch_limit in   max CLK cycles spent waiting for SCL high (0 = none)
//   scl_i         in   raw SCL pin level (asynchronous)
//   scl_t         out  tristate control: 1 = release, 0 = drive low
//   busy          out  high whenever not idle
//   fall_tick     out  strobe in the first cycle of each low phase
//   rise_tick     out  strobe in the first cycle of each high phase
//   low_mid       out  strobe at the middle of the low phase
//   high_mid      out  strobe at the middle of the high phase
//   stretching    out  high while waiting for SCL to read high
//   timeout       out  sticky: a stretch exceeded stretch_limit
// ----------------------------------------------------------------------------
module i2c_scl_gen #(
    parameter int DIV_W = 16,
    parameter int TO_W  = 20
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [DIV_W-1:0] half_period,
    input  logic [TO_W-1:0]  stretch_limit,
    input  logic             scl_i,
    output logic             scl_t,
    output logic             busy,
    output logic             fall_tick,
    output logic             rise_tick,
    output logic             low_mid,
    output logic             high_mid,
    output logic             stretching,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOW       = 2'd1,
        S_WAIT_HIGH = 2'd2,
        S_HIGH      = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_scl_s;
    logic [DIV_W-1:0] r_h;
    logic [DIV_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_st;

    logic             r_scl_t;
    logic             r_busy;
    logic             r_fall_tick;
    logic             r_rise_tick;
    logic             r_low_mid;
    logic             r_high_mid;
    logic             r_stretching;
    logic             r_timeout;

    logic [DIV_W-1:0] w_h_new;
    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W-1:0] w_half;
    logic             w_cnt_last;
    logic [TO_W-1:0]  w_st_inc;
    logic             w_to_hit;

    // H is clamped to 4 so the four phase strobes can never coincide and the
    // low phase outlasts the synchronizer's memory of the previous high level.
    assign w_h_new    = (half_period < DIV_W'(4)) ? DIV_W'(4) : half_period;

    // Saturating increments: counters hold at all-ones instead of wrapping.
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + DIV_W'(1);
    assign w_st_inc   = (r_st == '1) ? r_st : r_st + TO_W'(1);

    assign w_half     = r_h >> 1;
    assign w_cnt_last = (r_cnt >= r_h - DIV_W'(1));

    // w_st_inc counts the current WAIT_HIGH cycle, so a limit of N allows
    // exactly N cycles of waiting before giving up.
    assign w_to_hit   = (stretch_limit != '0) && (w_st_inc >= stretch_limit);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_sync1      <= 1'b0;
            r_scl_s      <= 1'b0;
            r_h          <= '0;
            r_cnt        <= '0;
            r_st         <= '0;
            r_scl_t      <= 1'b1;
            r_busy       <= 1'b0;
            r_fall_tick  <= 1'b0;
            r_rise_tick  <= 1'b0;
            r_low_mid    <= 1'b0;
            r_high_mid   <= 1'b0;
            r_stretching <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_sync1     <= scl_i;
            r_scl_s     <= r_sync1;

            r_fall_tick <= 1'b0;
            r_rise_tick <= 1'b0;
            r_low_mid   <= 1'b0;
            r_high_mid  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state     <= S_LOW;
                        r_h         <= w_h_new;
                        r_cnt       <= '0;
                        r_scl_t     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_timeout   <= 1'b0;
                        r_fall_tick <= 1'b1;
                    end
                end

                S_LOW: begin
                    if (w_cnt_last) begin
                        r_state      <= S_WAIT_HIGH;
                        r_st         <= '0;
                        r_scl_t      <= 1'b1;
                        r_stretching <= 1'b1;
                    end else begin
                        r_cnt     <= w_cnt_inc;
                        r_low_mid <= (w_cnt_inc == w_half);
                    end
                end

                S_WAIT_HIGH: begin
                    // A high bus in the same cycle as the limit takes priority.
                    if (r_scl_s) begin
                        r_state      <= S_HIGH;
                        r_cnt        <= '0;
                        r_rise_tick  <= 1'b1;
                        r_stretching <= 1'b0;
                    end else if (w_to_hit) begin
                        r_state      <= S_IDLE;
                        r_st         <= w_st_inc;
                        r_busy       <= 1'b0;
                        r_stretching <= 1'b0;
                        r_timeout    <= 1'b1;
                    end else begin
                        r_st <= w_st_inc;
                    end
                end

                S_HIGH: begin
                    if (w_cnt_last) begin
                        if (en) begin
                            r_state     <= S_LOW;
                            r_h         <= w_h_new;
                            r_cnt       <= '0;
                            r_scl_t     <= 1'b0;
                            r_fall_tick <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt      <= w_cnt_inc;
                        r_high_mid <= (w_cnt_inc == w_half);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_scl_t <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign scl_t      = r_scl_t;
    assign busy       = r_busy;
    assign fall_tick  = r_fall_tick;
    assign rise_tick  = r_rise_tick;
    assign low_mid    = r_low_mid;
    assign high_mid   = r_high_mid;
    assign stretching = r_stretching;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// ----------------------------------------------------------------------------
// tb_i2c_scl_gen
//
// Purpose:
//   Directed self-checking bench for i2c_scl_gen. The bus is modelled as a
//   pulled-up open-drain line (scl_i = scl_t) that a slave may hold low via
//   r_hold. A negedge monitor records the cycle number of every strobe so
//   phase offsets and periods can be compared against hand-computed values.
// ----------------------------------------------------------------------------
module tb_i2c_scl_gen;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en;
    logic [15:0] half_period;
    logic [19:0] stretch_limit;
    logic        scl_i;
    logic        scl_t;
    logic        busy;
    logic        fall_tick;
    logic        rise_tick;
    logic        low_mid;
    logic        high_mid;
    logic        stretching;
    logic        timeout;

    logic        r_hold;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int fall_q[$];
    int rise_q[$];
    int lm_q[$];
    int hm_q[$];
    int rel_q[$];
    int st_cnt  = 0;
    int coinc   = 0;
    logic prev_t = 1'b1;

    i2c_scl_gen #(
        .DIV_W(16),
        .TO_W (20)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .en           (en),
        .half_period  (half_period),
        .stretch_limit(stretch_limit),
        .scl_i        (scl_i),
        .scl_t        (scl_t),
        .busy         (busy),
        .fall_tick    (fall_tick),
        .rise_tick    (rise_tick),
        .low_mid      (low_mid),
        .high_mid     (high_mid),
        .stretching   (stretching),
        .timeout      (timeout)
    );

    // Open-drain bus with pull-up; a slave can only pull it low.
    assign scl_i = scl_t & ~r_hold;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (fall_tick)  fall_q.push_back(cyc);
        if (rise_tick)  rise_q.push_back(cyc);
        if (low_mid)    lm_q.push_back(cyc);
        if (high_mid)   hm_q.push_back(cyc);
        if (scl_t && !prev_t) rel_q.push_back(cyc);
        prev_t = scl_t;
        if (stretching) st_cnt++;
        if (int'(fall_tick) + int'(rise_tick) + int'(low_mid) + int'(high_mid) > 1)
            coinc++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        fall_q.delete();
        rise_q.delete();
        lm_q.delete();
        hm_q.delete();
        rel_q.delete();
        st_cnt = 0;
    endtask

    // Returns the cycle number of the first negedge where busy reads low.
    task automatic wait_idle(input string tag, input int budget, output int t);
        bit found;
        found = 1'b0;
        t = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge CLK);
            if (!busy) begin
                found = 1'b1;
                t = cyc;
            end
        end
        if (!found) check_eq({tag, "_idle_wait"}, 0, 1);
    endtask

    task automatic wait_falls(input string tag, input int n, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge CLK);
            if (fall_q.size() >= n) found = 1'b1;
        end
        if (!found) check_eq({tag, "_fall_wait"}, fall_q.size(), n);
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_scl_t"},      int'(scl_t),      1);
        check_eq({tag, "_busy"},       int'(busy),       0);
        check_eq({tag, "_fall"},       int'(fall_tick),  0);
        check_eq({tag, "_rise"},       int'(rise_tick),  0);
        check_eq({tag, "_lmid"},       int'(low_mid),    0);
        check_eq({tag, "_hmid"},       int'(high_mid),   0);
        check_eq({tag, "_stretching"}, int'(stretching), 0);
        check_eq({tag, "_timeout"},    int'(timeout),    0);
    endtask

    initial begin
        int c0;
        int t_idle;
        bit found;

        RST           = 1'b1;
        en            = 1'b0;
        half_period   = 16'd194;
        stretch_limit = 20'd0;
        r_hold        = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outs("rst");

        // 400 kHz operation; en is present in the very first cycle after reset.
        clr_log();
        RST = 1'b0;
        en  = 1'b1;
        c0  = cyc;
        wait_falls("nom", 3, 1500);
        en = 1'b0;
        wait_idle("nom", 800, t_idle);
        repeat (2) @(negedge CLK);
        if (fall_q.size() >= 3 && rise_q.size() >= 1 && lm_q.size() >= 1 &&
            hm_q.size() >= 1 && rel_q.size() >= 1) begin
            check_eq("nom_first_fall", fall_q[0] - c0, 1);
            check_eq("nom_period1",    fall_q[1] - fall_q[0], 391);
            check_eq("nom_period2",    fall_q[2] - fall_q[1], 391);
            check_eq("nom_low_len",    rel_q[0] - fall_q[0], 194);
            check_eq("nom_low_mid",    lm_q[0] - fall_q[0], 97);
            check_eq("nom_rise",       rise_q[0] - fall_q[0], 197);
            check_eq("nom_high_mid",   hm_q[0] - fall_q[0], 294);
        end else begin
            check_eq("nom_events", fall_q.size(), 3);
        end
        check_eq("nom_timeout", int'(timeout), 0);

        // half_period below the minimum clamps to H=4.
        clr_log();
        half_period = 16'd1;
        en = 1'b1;
        wait_falls("clamp", 2, 100);
        en = 1'b0;
        wait_idle("clamp", 100, t_idle);
        repeat (2) @(negedge CLK);
        if (fall_q.size() >= 2 && rise_q.size() >= 1 && lm_q.size() >= 1 && hm_q.size() >= 1) begin
            check_eq("clamp_period",   fall_q[1] - fall_q[0], 11);
            check_eq("clamp_low_mid",  lm_q[0] - fall_q[0], 2);
            check_eq("clamp_rise",     rise_q[0] - fall_q[0], 7);
            check_eq("clamp_high_mid", hm_q[0] - fall_q[0], 9);
        end else begin
            check_eq("clamp_events", fall_q.size(), 2);
        end

        // Slave stretches the low phase by 100 cycles after release.
        clr_log();
        half_period = 16'd10;
        r_hold = 1'b1;
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge CLK);
            if (fall_q.size() > 0 && scl_t) found = 1'b1;
        end
        if (!found) check_eq("str_release_wait", 0, 1);
        repeat (100) @(negedge CLK);
        r_hold = 1'b0;
        en = 1'b0;
        wait_idle("str", 300, t_idle);
        repeat (2) @(negedge CLK);
        if (fall_q.size() >= 1 && rise_q.size() >= 1) begin
            check_eq("str_rise", rise_q[0] - fall_q[0], 113);
            check_eq("str_idle", t_idle - fall_q[0], 123);
        end else begin
            check_eq("str_events", rise_q.size(), 1);
        end
        check_eq("str_cycles",  st_cnt, 103);
        check_eq("str_nfall",   fall_q.size(), 1);
        check_eq("str_timeout", int'(timeout), 0);

        // Bus stuck low with a 50-cycle stretch limit.
        clr_log();
        stretch_limit = 20'd50;
        r_hold = 1'b1;
        en = 1'b1;
        @(negedge CLK);
        en = 1'b0;
        wait_idle("to", 200, t_idle);
        repeat (2) @(negedge CLK);
        if (fall_q.size() >= 1)
            check_eq("to_idle_at", t_idle - fall_q[0], 60);
        check_eq("to_cycles",  st_cnt, 50);
        check_eq("to_flag",    int'(timeout), 1);
        check_eq("to_scl_t",   int'(scl_t), 1);
        check_eq("to_nrise",   rise_q.size(), 0);
        r_hold = 1'b0;
        en = 1'b1;
        @(negedge CLK);
        check_eq("to_clear",      int'(timeout), 0);
        check_eq("to_restart",    int'(fall_tick), 1);
        en = 1'b0;
        wait_idle("to2", 100, t_idle);
        stretch_limit = 20'd0;

        // half_period changes mid-LOW only apply from the next low phase.
        clr_log();
        half_period = 16'd20;
        en = 1'b1;
        repeat (11) @(negedge CLK);
        half_period = 16'd30;
        wait_falls("hp", 3, 300);
        en = 1'b0;
        wait_idle("hp", 200, t_idle);
        if (fall_q.size() >= 3) begin
            check_eq("hp_period_old", fall_q[1] - fall_q[0], 43);
            check_eq("hp_period_new", fall_q[2] - fall_q[1], 63);
        end else begin
            check_eq("hp_events", fall_q.size(), 3);
        end

        // en dropped at LOW counter 10: the cycle completes, no further fall.
        clr_log();
        half_period = 16'd20;
        en = 1'b1;
        repeat (11) @(negedge CLK);
        en = 1'b0;
        wait_idle("stop", 200, t_idle);
        repeat (5) @(negedge CLK);
        if (fall_q.size() >= 1)
            check_eq("stop_idle_at", t_idle - fall_q[0], 43);
        check_eq("stop_nfall",  fall_q.size(), 1);
        check_eq("stop_nhmid",  hm_q.size(), 1);
        check_eq("stop_scl_t",  int'(scl_t), 1);

        // Reset while a slave is stretching.
        clr_log();
        half_period = 16'd10;
        r_hold = 1'b1;
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge CLK);
            if (stretching) found = 1'b1;
        end
        if (!found) check_eq("rstw_stretch_wait", 0, 1);
        repeat (5) @(negedge CLK);
        check_eq("rstw_pre_stretch", int'(stretching), 1);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outs("rstw");
        RST = 1'b0;
        en = 1'b0;
        r_hold = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rstw_stay_idle", int'(busy), 0);

        check_eq("strobe_coincidence", coinc, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
